ppt_controller: RTL
===================

PPT_CONTROLLER -- requirements
Module: ppt_controller

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 32, prescaler counter width; must be at least 32.
REQ-002 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port clk_div, input, 5, tick divider exponent; one tick equals 2^(clk_div+1) clk cycles.
REQ-005 SHALL have port period, input, 14, firing period in ticks.
REQ-006 SHALL have port width, input, 14, pulse high time in ticks.
REQ-007 SHALL have port count, input, 8, number of firings per run.
REQ-008 SHALL have port run_ppt, input, 1, level run request; a rising edge starts a run and a low level aborts it.
REQ-009 SHALL have port pulse_out, output, 1, thruster fire pulse.
REQ-010 SHALL have port count_done, output, 8, firings completed in the current or last run.
REQ-011 SHALL have port done, output, 1, run completed.
REQ-012 SHALL have port busy, output, 1, high in states FIRE and GAP.

Function
REQ-013 SHALL implement states IDLE, FIRE, GAP and DONE.
REQ-014 SHALL, on a 0->1 run_ppt transition sampled in IDLE, snapshot clk_div, period, width and count, clear count_done and the prescaler, and enter FIRE on the next cycle.
  - Input changes during a run SHALL be ignored.
REQ-015 SHALL NOT start a run if run_ppt is already high on reset release; a fresh 0->1 edge is required.
REQ-016 SHALL use effective values P = max(period,1) and W = min(width, P-1).
REQ-017 SHALL drive pulse_out high for exactly W*2^(clk_div+1) clk cycles from FIRE entry, then low.
  - Each firing, from FIRE entry to FIRE entry, SHALL last P*2^(clk_div+1) cycles.
REQ-018 SHALL register pulse_out with no combinational path from inputs.
REQ-019 SHALL stay in FIRE with pulse_out low when W=0, and still count the firing.
REQ-020 SHALL increment count_done by 1 in the cycle a firing period ends.
  - It SHALL then go to FIRE if count_done+1 < count, else to DONE.
REQ-021 SHALL go directly from IDLE to DONE with count_done=0 on a start with count=0, unless PPT_CONTINUOUS_EN applies.
REQ-022 SHALL hold done=1, pulse_out=0 and count_done frozen in DONE until run_ppt=0, then go to IDLE.
  - done SHALL clear in the IDLE entry cycle; count_done SHALL keep its value.
REQ-023 SHALL, on run_ppt=0 during FIRE or GAP, force pulse_out=0 and go to IDLE in the next cycle.
  - count_done SHALL keep the completed firings, and done SHALL stay 0.
REQ-024 SHALL clamp count_done at 255 and never wrap.

Reset
REQ-025 SHALL, on rst, asynchronously set state=IDLE, pulse_out=0, count_done=0, done=0, busy=0, clear the prescaler and snapshot registers, and clear the run-edge detector to 0.
REQ-026 SHALL give a reset asserted mid-pulse the same behaviour as REQ-025 within the same cycle; pulse_out drops without waiting for clk.

Configuration
REQ-027 SHALL, with macro PPT_CONTINUOUS_EN defined, treat a snapshot count=0 as unlimited firings until run_ppt falls.
  - count_done SHALL saturate per REQ-024, and done SHALL never assert in this mode.
REQ-028 SHALL, without PPT_CONTINUOUS_EN, apply REQ-021 for count=0.

Structure
REQ-029 SHALL take from shared package ppt_pkg: the state enum (IDLE, FIRE, GAP, DONE), widths CLKDIV_W=5, TIME_W=14 and CNT_W=8, and the reset-default constants used by the register block.
REQ-030 SHALL contain one sub-module, ppt_prescaler, with inputs clk, rst, clear and clk_div, producing a one-cycle tick pulse every 2^(clk_div+1) cycles.
REQ-031 SHALL make the tick counter in ppt_controller TIME_W bits wide, compared against W and P.

Verification
REQ-032 SHALL be verified with clk_div=0, period=4, width=1, count=3, run 0->1.
  - Three pulses, each 2 clk high then 6 clk low; count_done steps 1,2,3; done=1 at 24 cycles after FIRE entry.
REQ-033 SHALL be verified with period=2, width=5.
  - Width is clamped to 1 tick: pulse 2 clk high, 2 clk low per firing.
REQ-034 SHALL be verified with count=0 in both builds.
  - Without the macro: done=1 next cycle, no pulse.
  - With PPT_CONTINUOUS_EN: more than 300 firings, count_done holds 255, done=0.
REQ-035 SHALL be verified with run_ppt dropped mid-pulse in the second firing, count=5.
  - pulse_out=0 in the next cycle, state IDLE, count_done=1, done=0.
REQ-036 SHALL be verified with rst asserted mid-pulse and run_ppt held high through rst release.
  - Immediate pulse_out=0, all outputs 0, no restart until run_ppt toggles 0->1.
REQ-037 SHALL be verified with period and width changed mid-run.
  - Timing is unaffected until the next run.

Source files
------------

// File: rtl/ppt_pkg.sv
// Shared types, widths and reset defaults for the pulsed plasma thruster controller.
package ppt_pkg;
   localparam int CLKDIV_W = 5;
   localparam int TIME_W   = 14;
   localparam int CNT_W    = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FIRE = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } ppt_state_e;

   localparam ppt_state_e              RST_STATE = IDLE;
   localparam logic [CLKDIV_W-1:0]     RST_DIV   = {CLKDIV_W{1'b0}};
   localparam logic [TIME_W-1:0]       RST_TIME  = {TIME_W{1'b0}};
   localparam logic [CNT_W-1:0]        RST_CNT   = {CNT_W{1'b0}};
   localparam logic                    RST_FLAG  = 1'b0;
   localparam logic [TIME_W-1:0]       ONE_TIME  = {{(TIME_W-1){1'b0}}, 1'b1};

   // Saturating increment so the firing counter never wraps.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == {CNT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction
endpackage

// File: rtl/ppt_prescaler.sv
// Free-running tick generator: one-cycle tick every 2^(clk_div+1) clk cycles.
module ppt_prescaler
   import ppt_pkg::*;
#(
   parameter int PRESCALE_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic [CLKDIV_W-1:0] clk_div,
   output logic                tick
);

   localparam logic [PRESCALE_W-1:0] ONE_P = {{(PRESCALE_W-1){1'b0}}, 1'b1};

   logic [PRESCALE_W-1:0] cnt_r;
   logic [PRESCALE_W-1:0] term_s;

   // Terminal count is clk_div+1 low-order ones.
   always_comb begin
      term_s = {PRESCALE_W{1'b0}};
      for (int i = 0; i < PRESCALE_W; i++) begin
         term_s[i] = (i <= int'(clk_div));
      end
   end

   // Prescaler counter; clear realigns ticks to the start of a run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= {PRESCALE_W{1'b0}};
      end else if (clear) begin
         cnt_r <= {PRESCALE_W{1'b0}};
      end else if (cnt_r == term_s) begin
         cnt_r <= {PRESCALE_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + ONE_P;
      end
   end

   assign tick = (cnt_r == term_s);

endmodule

// File: rtl/ppt_controller.sv
// Thruster fire sequencer: runs `count` firings of `period` ticks with a `width`-tick pulse.
// Optional build macro PPT_CONTINUOUS_EN makes count=0 fire until run_ppt falls.
module ppt_controller
   import ppt_pkg::*;
#(
   parameter int PRESCALE_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CLKDIV_W-1:0] clk_div,
   input  logic [TIME_W-1:0]   period,
   input  logic [TIME_W-1:0]   width,
   input  logic [CNT_W-1:0]    count,
   input  logic                run_ppt,
   output logic                pulse_out,
   output logic [CNT_W-1:0]    count_done,
   output logic                done,
   output logic                busy
);

   ppt_state_e          state_r, state_nx_s;
   logic                armed_r;
   logic [CLKDIV_W-1:0] div_r;
   logic [TIME_W-1:0]   per_r, wid_r, tick_cnt_r, tick_nx_s;
   logic [CNT_W-1:0]    cnt_r, cdone_r, cdone_nx_s;
   logic                pulse_r, done_r, busy_r, pulse_nx_s;
   logic                start_s, start_fire_s, more_s, tick_s;
   logic [TIME_W-1:0]   per_eff_s, wid_eff_s, wid_nx_s;

   ppt_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
      .clk     (clk),
      .rst     (rst),
      .clear   (start_s),
      .clk_div (div_r),
      .tick    (tick_s)
   );

   // Start qualification, effective timing values and run-continuation decision.
   always_comb begin
      start_s   = (state_r == IDLE) && armed_r && run_ppt;
      per_eff_s = (period == RST_TIME) ? ONE_TIME : period;
      wid_eff_s = (width < per_eff_s) ? width : (per_eff_s - ONE_TIME);
      wid_nx_s  = start_s ? wid_eff_s : wid_r;
`ifdef PPT_CONTINUOUS_EN
      start_fire_s = 1'b1;
      more_s = (cnt_r == RST_CNT) || (({1'b0, cdone_r} + 9'd1) < {1'b0, cnt_r});
`else
      start_fire_s = (count != RST_CNT);
      more_s = (({1'b0, cdone_r} + 9'd1) < {1'b0, cnt_r});
`endif
   end

   // Next-state, tick counter and firing counter.
   always_comb begin
      state_nx_s = state_r;
      tick_nx_s  = tick_cnt_r;
      cdone_nx_s = cdone_r;
      case (state_r)
         IDLE: begin
            if (start_s) begin
               tick_nx_s  = RST_TIME;
               cdone_nx_s = RST_CNT;
               state_nx_s = start_fire_s ? FIRE : DONE;
            end else begin
               state_nx_s = IDLE;
            end
         end
         FIRE, GAP: begin
            if (!run_ppt) begin
               state_nx_s = IDLE;
            end else if (tick_s && (tick_cnt_r == (per_r - ONE_TIME))) begin
               tick_nx_s  = RST_TIME;
               cdone_nx_s = sat_inc(cdone_r);
               state_nx_s = more_s ? FIRE : DONE;
            end else if (tick_s) begin
               tick_nx_s = tick_cnt_r + ONE_TIME;
               if ((state_r == FIRE) && ((tick_cnt_r + ONE_TIME) == wid_r)) begin
                  state_nx_s = GAP;
               end else begin
                  state_nx_s = state_r;
               end
            end else begin
               state_nx_s = state_r;
            end
         end
         DONE: begin
            if (!run_ppt) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = DONE;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
      // A zero-width pulse keeps FIRE but never raises the output.
      pulse_nx_s = (state_nx_s == FIRE) && (wid_nx_s != RST_TIME);
   end

   // State, snapshot and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= RST_STATE;
         armed_r    <= RST_FLAG;
         div_r      <= RST_DIV;
         per_r      <= RST_TIME;
         wid_r      <= RST_TIME;
         cnt_r      <= RST_CNT;
         tick_cnt_r <= RST_TIME;
         cdone_r    <= RST_CNT;
         pulse_r    <= RST_FLAG;
         done_r     <= RST_FLAG;
         busy_r     <= RST_FLAG;
      end else begin
         state_r    <= state_nx_s;
         armed_r    <= ~run_ppt;
         tick_cnt_r <= tick_nx_s;
         cdone_r    <= cdone_nx_s;
         pulse_r    <= pulse_nx_s;
         done_r     <= (state_nx_s == DONE);
         busy_r     <= (state_nx_s == FIRE) || (state_nx_s == GAP);
         if (start_s) begin
            div_r <= clk_div;
            per_r <= per_eff_s;
            wid_r <= wid_eff_s;
            cnt_r <= count;
         end else begin
            div_r <= div_r;
            per_r <= per_r;
            wid_r <= wid_r;
            cnt_r <= cnt_r;
         end
      end
   end

   assign pulse_out  = pulse_r;
   assign count_done = cdone_r;
   assign done       = done_r;
   assign busy       = busy_r;

endmodule
